// File: rtl/logicnet_pkg.sv
// Shared types and helpers for the LogicNets input front-end.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
// Contents: fsm_state_t (FILL/HOLD/DISCARD) and quantize(), the uniform
// saturating quantizer shared by the RTL and the reference model.
package logicnet_pkg;

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } fsm_state_t;

    // Uniform quantizer: t = (x >>> shift) + offset, then clamp to
    // [0, 2^qbits-1]. The caller passes x already sign-extended to 32 bits.
    // For input widths up to 30 bits, the 32-bit arithmetic matches an
    // IN_W+2 bit datapath exactly.
    function automatic int quantize(input int x, input int shift,
                                    input int offset, input int qbits);
        int t;
        int lim;
        t   = (x >>> shift) + offset;
        lim = (1 << qbits) - 1;
        if (t < 0) begin
            return 0;
        end
        if (t > lim) begin
            return lim;
        end
        return t;
    endfunction

endpackage

// File: rtl/logicnet_input_packer_if.sv
// Stream bundle between a feature source, the input packer and layer-0.
// Latency: n/a (wires only).
// Backpressure: s_valid/s_ready on the feature side, m_valid/m_ready on the frame side.
// master: drives the features and the frame-side ready (source and sink side).
// slave:  the packer itself.
interface logicnet_input_packer_if #(
    parameter int N_FEATURES = 16,
    parameter int IN_W       = 16,
    parameter int QBITS      = 2
);
    logic                          s_valid;
    logic                          s_ready;
    logic signed [IN_W-1:0]        s_data;
    logic                          s_last;
    logic                          m_valid;
    logic                          m_ready;
    logic [N_FEATURES*QBITS-1:0]   m_data;

    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_data
    );

    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_data
    );
endinterface

// File: rtl/logicnet_quantizer.sv
// Combinational signed feature -> QBITS code with saturation.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; this block is a function of d only.
// Ports: d (IN_W signed feature in), q (QBITS code out).
module logicnet_quantizer
    import logicnet_pkg::*;
#(
    parameter int IN_W   = 16,
    parameter int QBITS  = 2,
    parameter int SHIFT  = 8,
    parameter int OFFSET = 2
) (
    input  logic signed [IN_W-1:0] d,
    output logic [QBITS-1:0]       q
);
    always_comb begin
        q = QBITS'(quantize(32'(d), SHIFT, OFFSET, QBITS));
    end
endmodule

// File: rtl/logicnet_input_packer.sv
// Quantizes a stream of features and packs a full frame for the layer-0 LUTs.
// Latency: m_valid rises the cycle after the last feature transfer.
// Backpressure: s_ready drops while a frame is held; m_data frozen until m_ready.
// Ports: clk, rst (sync, active high); bus (slave view of the stream
// bundle); frame_err (one-cycle pulse per dropped frame); err_count
// (saturating count of dropped frames).
module logicnet_input_packer
    import logicnet_pkg::*;
#(
    parameter int N_FEATURES = 16,
    parameter int IN_W       = 16,
    parameter int QBITS      = 2,
    parameter int SHIFT      = 8,
    parameter int OFFSET     = 2,
    parameter int ERR_W      = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    logicnet_input_packer_if.slave      bus,
    output logic                        frame_err,
    output logic [ERR_W-1:0]            err_count
);
    localparam int IDX_W = $clog2(N_FEATURES);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_FEATURES - 1);

    fsm_state_t                  state, state_nxt;
    logic [IDX_W-1:0]            idx, idx_nxt;
    logic                        s_ready_q;
    logic                        m_valid_q;
    logic [N_FEATURES*QBITS-1:0] m_data_q;
    logic                        frame_err_q;
    logic [ERR_W-1:0]            err_cnt_q;
    logic                        fire;
    logic                        wr_en;
    logic                        err_nxt;
    logic [QBITS-1:0]            q;

    logicnet_quantizer #(
        .IN_W   (IN_W),
        .QBITS  (QBITS),
        .SHIFT  (SHIFT),
        .OFFSET (OFFSET)
    ) u_quant (
        .d (bus.s_data),
        .q (q)
    );

    // s_ready is a flop, so a transfer is qualified only by registered state.
    assign fire = bus.s_valid & s_ready_q;

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        err_nxt   = 1'b0;
        wr_en     = 1'b0;
        case (state)
            FILL: begin
                if (fire) begin
                    wr_en = 1'b1;
                    if (bus.s_last) begin
                        idx_nxt = '0;
                        if (idx == LAST) begin
                            state_nxt = HOLD;
                        end else begin
                            err_nxt = 1'b1;     // short frame
                        end
                    end else if (idx == LAST) begin
                        idx_nxt   = '0;
                        err_nxt   = 1'b1;       // long frame: drop the tail
                        state_nxt = DISCARD;
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (bus.m_ready) begin
                    state_nxt = FILL;
                end
            end
            DISCARD: begin
                if (fire && bus.s_last) begin
                    state_nxt = FILL;
                    idx_nxt   = '0;
                end
            end
            default: begin
                state_nxt = FILL;
                idx_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FILL;
            idx         <= '0;
            s_ready_q   <= 1'b0;
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            frame_err_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state       <= state_nxt;
            idx         <= idx_nxt;
            // Handshake outputs are registered copies of the next state, so
            // m_ready never reaches s_ready combinationally.
            s_ready_q   <= (state_nxt != HOLD);
            m_valid_q   <= (state_nxt == HOLD);
            frame_err_q <= err_nxt;
            if (wr_en) begin
                m_data_q[idx*QBITS +: QBITS] <= q;
            end
            if (err_nxt && (err_cnt_q != {ERR_W{1'b1}})) begin
                err_cnt_q <= err_cnt_q + 1'b1;
            end
        end
    end

    assign bus.s_ready = s_ready_q;
    assign bus.m_valid = m_valid_q;
    assign bus.m_data  = m_data_q;
    assign frame_err   = frame_err_q;
    assign err_count   = err_cnt_q;
endmodule

// File: doc/logicnet_input_packer.md
# logicnet_input_packer

Front-end stage that feeds the first LogicNets neuron layer (`layer0_*` truth-table modules). It accepts one signed fixed-point feature per cycle over a valid/ready stream and uniformly quantizes each feature to QBITS with saturation. It packs a full frame of N_FEATURES codes into one flat vector, and holds it stable for the combinational layer-0 LUTs until the downstream register stage accepts it. Malformed frames (wrong length vs. `s_last`) are dropped and counted.

## Interface
- `N_FEATURES`, 16: features per frame; ≥2.
- `IN_W`, 16: signed input feature width.
- `QBITS`, 2: code width per feature, as consumed by layer-0 fan-in slices.
- `SHIFT`, 8: arithmetic right shift applied before offset.
- `OFFSET`, 2: signed offset added after shift.
- `ERR_W`, 16: error counter width.

- `clk`  in  1  sole clock; all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `s_valid`  in  1  input feature valid.
- `s_ready`  out  1  packer can accept a feature.
- `s_data`  in  IN_W  signed feature, two's complement.
- `s_last`  in  1  marks final feature of a frame.
- `m_valid`  out  1  packed frame valid.
- `m_ready`  in  1  downstream accepts frame.
- `m_data`  out  N_FEATURES*QBITS  packed codes; feature i at `[i*QBITS +: QBITS]`, i = arrival order from 0.
- `frame_err`  out  1  one-cycle pulse on a dropped frame.
- `err_count`  out  ERR_W  saturating count of dropped frames.

## Operation
- Quantize (combinational on `s_data`): `t = (s_data >>> SHIFT) + OFFSET`, computed at IN_W+2 bits signed. `q = 0` if t<0; `q = 2^QBITS−1` if t>2^QBITS−1; else `t[QBITS-1:0]`.
- Transfer occurs when valid&ready are both high on the same edge; data is ignored otherwise.
- FSM states:
  - FILL: `s_ready=1`. On transfer, write q into slot `idx` and increment `idx`.
    - `s_last` with idx==N_FEATURES−1: go to HOLD, idx←0.
    - `s_last` with idx<N_FEATURES−1 (short frame): pulse `frame_err`, idx←0, stay in FILL.
    - No `s_last` with idx==N_FEATURES−1 (long frame): pulse `frame_err`, go to DISCARD.
  - HOLD: `m_valid=1`, `s_ready=0`, `m_data` frozen. On `m_ready`, go to FILL.
  - DISCARD: `s_ready=1`, features dropped. Transfer with `s_last` → FILL, idx←0; no further error pulse.
- `err_count` increments on each `frame_err` pulse and saturates at all-ones.
- Slots not written since the last completed frame retain old values. This is invisible, because `m_valid` is only raised after a full frame.

## Timing
- Reset values: `s_ready=0` during the reset cycle, then 1 (FILL); `m_valid=0`, `m_data=0`, `frame_err=0`, `err_count=0`, idx=0, state FILL.
- `s_ready` and `m_valid` come from registered state only; no combinational path from `m_ready` to `s_ready`.
- Latency: `m_valid` rises the cycle after the final feature transfer.
- Throughput: one frame per N_FEATURES+1 cycles with `m_ready` held high.
- `m_data` is registered and stable throughout HOLD. It may change only on FILL transfers.
- `frame_err` is registered: it is high exactly the cycle after the offending transfer.
- `rst` mid-frame or mid-HOLD discards everything: no `m_valid` and no error count.
- `m_ready` outside HOLD has no effect.

## Structure
- Shared package `logicnet_pkg`:
  - state enum {FILL, HOLD, DISCARD};
  - the quantize function, parameterized by IN_W/QBITS/SHIFT/OFFSET, reused by the bench's reference model.
- One sub-module: `logicnet_quantizer`, a combinational `s_data` → q block. It is instanced once here and is reusable for other layers' input widths.
- idx counter width: `$clog2(N_FEATURES)`.

## Test plan
All scenarios use N_FEATURES=4, QBITS=2, SHIFT=8, OFFSET=2.
- Quantize sweep, `m_ready=1`:
  - features 0, −256, −1024, 300 with `s_last` on the 4th;
  - requires `m_valid` one cycle later with `m_data=8'b11_00_01_10`;
  - requires 32767 → code 3 and −32768 → code 0.
- Back-pressure: hold `m_ready=0` for 10 cycles after a frame.
  - `m_valid` and `m_data` must stay constant and `s_ready` must stay 0.
  - `m_ready=1` → FILL next cycle, and the next frame is accepted.
- Short frame: `s_last` on the 2nd feature.
  - Requires a `frame_err` pulse, `err_count=1` and no `m_valid`.
  - A following correct frame is output normally.
- Long frame: 6 features, `s_last` on the 6th.
  - Requires one `frame_err` pulse after the 4th, features 5–6 dropped, `err_count=1`.
  - Next frame is correct.
- `s_valid` gaps: random idle cycles between features give the same packed result as the gap-free case. Reset asserted after 2 features gives no output; a fresh 4-feature frame then packs from slot 0.
- Counter saturation: ERR_W=2, 5 short frames → `err_count` stops at 3.
